// File: rtl/main_mem_arbiter.sv
// Shares one main-memory port between instruction refill and the data cache.
// Data wins by default; instruction fetch is guaranteed a grant after STARVE_LIMIT data grants.
module main_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ALIGN = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              own_d_q, own_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TW-1:0]     to_q, to_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              i_err_q, i_err_d, d_err_q, d_err_d;
    logic              grant_d, grant_i;

    // Instruction wins a simultaneous request only once the starvation count is exhausted.
    assign grant_d = d_req && !(i_req && (starve_q == SLIM));
    assign grant_i = i_req && !grant_d;

    always_comb begin
        state_d   = state_q;
        own_d_d   = own_d_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        to_d      = to_q;
        starve_d  = starve_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_err_d   = i_err_q;
        d_err_d   = d_err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    own_d_d = 1'b1;
                    addr_d  = d_addr & ALIGN;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    to_d    = '0;
                    state_d = S_BUSY_D;
                    if (i_req && (starve_q != SLIM))
                        starve_d = starve_q + SW'(1);
                end else if (grant_i) begin
                    own_d_d  = 1'b0;
                    addr_d   = i_addr & ALIGN;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    to_d     = '0;
                    starve_d = '0;
                    state_d  = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (mem_ready) begin
                    if (own_d_d) begin
                        d_err_d = 1'b0;
                        if (!we_q) d_rdata_d = mem_rdata;
                    end else begin
                        i_err_d = 1'b0;
                        i_rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else if (to_q == TLAST) begin
                    if (own_d_q) d_err_d = 1'b1;
                    else         i_err_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            own_d_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            to_q      <= '0;
            starve_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_d_q   <= own_d_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            to_q      <= to_d;
            starve_q  <= starve_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
        end
    end

    assign mem_req   = (state_q == S_BUSY_I) || (state_q == S_BUSY_D);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign i_ack     = (state_q == S_RESP) && !own_d_q;
    assign d_ack     = (state_q == S_RESP) && own_d_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_err     = i_err_q;
    assign d_err     = d_err_q;
endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Two-port arbiter and sequencer for the single main-memory port shared by the instruction-fetch refill path and the data cache (read-miss refill and write-through). Requests are granted with fixed data-over-instruction priority, bounded by a starvation limit for instruction fetch. Each transaction is sequenced through a memory request/ready handshake with timeout protection. It sits between the instruction-fetch stage and data cache above, and the main memory below; its acks release the pipeline's cache/fetch stalls.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 3, consecutive data grants allowed while an instruction request waits
- TIMEOUT, 16, max cycles in a busy state without mem_ready before abort

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_req  in  1  instruction read request, held until i_ack
- i_addr  in  ADDR_W  instruction byte address
- i_ack  out  1  one-cycle completion pulse, instruction port
- i_rdata  out  DATA_W  fetched word, valid when i_ack=1
- i_err  out  1  timeout flag, valid when i_ack=1
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=write, 0=read; stable while d_req=1
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle completion pulse, data port
- d_rdata  out  DATA_W  read word, valid when d_ack=1 and d_we=0
- d_err  out  1  timeout flag, valid when d_ack=1
- mem_req  out  1  memory access in progress
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle memory completion
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: if d_req and i_req, grant D unless starve_cnt == STARVE_LIMIT, in which case grant I. If only one request is present, grant it. If neither is present, stay in IDLE.
- On grant: latch owner, word-aligned address, we (0 for I), and wdata. Clear timeout counter. Go to BUSY_I or BUSY_D.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each D grant made while i_req=1.
  - Clears on every I grant.
  - Unchanged on a D grant with i_req=0.
- BUSY_x:
  - mem_req=1; mem_we, mem_addr and mem_wdata are driven from the latched values.
  - On mem_ready=1: capture mem_rdata into the owner's rdata register (reads only), clear err, go to RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 without ready, set the owner's err and go to RESP. The rdata register is unchanged.
- RESP: pulse the owner's ack for exactly one cycle, then go to IDLE. Requests are ignored in RESP. A requester must drop req at the edge where it samples ack; a req still high in the following IDLE cycle is treated as a new request.
- Write transactions leave d_rdata unchanged.
- i_rdata/d_rdata hold their last value between acks.
- mem_ready in IDLE or RESP is ignored.
- Address bits [1:0] are discarded; no misalignment error is reported.

## Timing
- Reset (synchronous): state=IDLE, starve_cnt=0, timeout counter=0. All outputs are 0: i_ack, d_ack, i_err, d_err, i_rdata, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy.
- Reset mid-transaction aborts with no ack. mem_req drops in the cycle after the reset edge.
- Request is sampled at edge N; mem_req is high from cycle N+1.
- If mem_ready arrives in the L-th mem_req cycle, ack is high in the cycle after it. End-to-end: ack is L+1 cycles after the request is first seen.
- The minimum back-to-back spacing is L+2 cycles per transaction, including one IDLE cycle.
- Timeout: ack with err=1 occurs in the cycle after the TIMEOUT-th mem_req cycle.
- mem_* outputs are registered and stable for the whole BUSY state.

## Test plan
- Single instruction read: i_req with i_addr=0x0000_0106, memory latency 3 returning 0xDEADBEEF. Required: mem_addr=0x0000_0104, mem_we=0, mem_req high for 3 cycles, i_ack one cycle later with i_rdata=0xDEADBEEF and i_err=0.
- Simultaneous requests (both in the same cycle): D granted first, d_ack first. I is then granted in the IDLE cycle after d_ack.
- Starvation: d_req re-raised continuously while i_req stays high, STARVE_LIMIT=3. Required grant order is D, D, D, I, then D again.
- Data write: d_we=1, d_addr=32, d_wdata=0x1234. Required: mem_we=1, mem_addr=32, mem_wdata=0x1234; d_ack with d_rdata unchanged.
- Timeout: mem_ready held 0, TIMEOUT=16. Required: mem_req high for 16 cycles, then d_ack=1 with d_err=1. A following transaction with latency 2 completes with d_err=0.
- Reset in the second BUSY cycle: no ack; all outputs are 0 the next cycle. A new i_req then completes normally with starve_cnt=0.
